// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-format defaults
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_TICKS = 16;

  // Tick counter must cover both the per-bit count and the stop-state count.
  function automatic int unsigned cnt_width(input int unsigned os, input int unsigned st);
    return $clog2((os > st) ? os : st);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned STOP_TICKS = UART_STOP_TICKS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx_ready,
  output logic                 tx_done_tick,
  output logic                 tx
);

  localparam int unsigned      CNT_W     = cnt_width(OVERSAMPLE, STOP_TICKS);
  localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);
  localparam logic [2:0]       N_LAST    = 3'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [CNT_W-1:0]     s_cnt_q;
  logic [2:0]           n_cnt_q;
  logic [DATA_BITS-1:0] b_q;
  logic                 tx_q;
  logic                 done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // tx_q is loaded with the level of the state being entered, so the line
  // is registered yet changes on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_cnt_q  <= '0;
      n_cnt_q  <= '0;
      b_q      <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            b_q      <= din;
            s_cnt_q  <= '0;
            tx_q     <= 1'b0;
            state_q  <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^din;
`endif
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_cnt_q == OS_LAST) begin
              s_cnt_q <= '0;
              n_cnt_q <= '0;
              tx_q    <= b_q[0];
              state_q <= ST_DATA;
            end else begin
              s_cnt_q <= s_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt_q == OS_LAST) begin
              b_q     <= b_q >> 1;
              s_cnt_q <= '0;
              if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
`endif
              end else begin
                n_cnt_q <= n_cnt_q + 3'd1;
                tx_q    <= b_q[1];
              end
            end else begin
              s_cnt_q <= s_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_cnt_q == OS_LAST) begin
              s_cnt_q <= '0;
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              s_cnt_q <= s_cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          tx_q <= 1'b1;
          if (s_tick) begin
            if (s_cnt_q == STOP_LAST) begin
              s_cnt_q <= '0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              s_cnt_q <= s_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready     = (state_q == ST_IDLE);
  assign tx_done_tick = done_q;
  assign tx           = tx_q;

endmodule
